tensorproduct_stream: RTL and testbench
=======================================

Name: tensorproduct_stream

Overview:
- Sequential, parametrised Kronecker (tensor) product engine for complex fixed-point matrices of arbitrary sizes D1 and D2.
- Time-multiplexes one pipelined complex multiplier instead of instantiating (D1*D2)^2 of them, so larger gate-matrix products fit on the FPGA.
- Operands are captured on a start handshake. Result elements stream out in row-major Kronecker order on a valid/ready interface with backpressure.
- Sits between the per-qubit gate generators and the state-vector/unitary update logic.

Parameters:
- N, 16, signed two's-complement element width (real and imaginary parts each).
- FRAC, 14, fractional bits of the fixed-point format; 1.0 = 2^FRAC.
- D1, 2, dimension of mat_1 (D1 x D1).
- D2, 2, dimension of mat_2 (D2 x D2).
- Derived localparams: DD = D1*D2, OUT_ELEMS = DD*DD, IDXW = max(1, $clog2(OUT_ELEMS)).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start_valid  in  1  request a new product.
- start_ready  out  1  high only in IDLE; a start is accepted when start_valid && start_ready.
- mat_1  in  [N-1:0] x (2*D1*D1)  element e has real part at [2e] and imaginary part at [2e+1]; e = row*D1+col.
- mat_2  in  [N-1:0] x (2*D2*D2)  same packing, e = row*D2+col.
- o_valid  out  1  output element present.
- o_ready  in  1  consumer accepts the element when o_valid && o_ready.
- o_re  out  N  real part of the current output element.
- o_im  out  N  imaginary part of the current output element.
- o_idx  out  IDXW  output index k = r*DD+c.
- o_last  out  1  high with element k = OUT_ELEMS-1.
- o_ovr  out  1  the current element saturated.
- ovr_flag  out  1  sticky: some element of the current job saturated.
- busy  out  1  high in RUN or DRAIN.

Behaviour:
- Reset (async, rst_n=0): state IDLE; all counters and pipeline valids cleared. Outputs: start_ready=1, o_valid=0, o_re=0, o_im=0, o_idx=0, o_last=0, o_ovr=0, ovr_flag=0, busy=0. A reset mid-job aborts it with no partial output.
- Operand capture: mat_1 and mat_2 are registered internally on the accept edge. Input changes after that edge have no effect on the job.
- States:
  - IDLE: start accept -> RUN; ovr_flag cleared on the same edge.
  - RUN: issue one element per advance, then -> DRAIN when element OUT_ELEMS-1 is issued.
  - DRAIN: wait until the last element handshake completes -> IDLE.
- Issue order: four nested counters j2 (fastest), j1, i2, i1 (slowest), each wrapping at its dimension.
  - Row r = i1*D2+i2, column c = j1*D2+j2.
  - Operands: a+jb = mat_1[i1*D1+j1] and c+jd = mat_2[i2*D2+j2].
  - Issued k values are strictly 0..OUT_ELEMS-1, in increasing order.
- Pipeline has 2 stages and one global advance enable, adv = !o_valid || o_ready.
  - S1 registers the four 2N-bit products a*c, b*d, a*d, b*c, plus the element's idx and last.
  - S2 (output register) computes re = ac-bd and im = ad+bc at full 2N+1-bit width, arithmetic-shifts right by FRAC (truncation toward -inf), then saturates to [-2^(N-1), 2^(N-1)-1].
  - o_ovr = 1 if either part saturated. ovr_flag |= o_ovr at capture.
- Stall: when adv=0, every pipeline register and issue counter holds, and outputs are stable until the handshake. There is no skid buffer and no element loss or duplication.
- Latency: element 0 is in S1 after the 1st edge following accept and o_valid=1 after the 2nd. With o_ready held at 1, the job sustains one element per cycle and finishes OUT_ELEMS+1 cycles after accept.
- Completion: on the edge where o_last is handshaken, state -> IDLE, o_valid=0 (unless another element follows, which cannot happen), start_ready=1 from the next cycle. A start cannot be accepted in the same cycle as the last handshake.
- Start while busy: ignored (start_ready=0).
- ovr_flag holds its value after the job until the next accept.

Test Plan:
- Identity x identity: D1=D2=2, FRAC=14, diagonal elements 16384+0j, off-diagonal 0, o_ready=1 -> 16 elements, o_idx 0..15. k in {0,5,10,15} gives o_re=16384, o_im=0; all others give 0. o_valid rises 2 edges after accept, o_last at k=15, ovr_flag=0.
- Ordering: mat_1[e] = (e+1)*1024 + 0j, mat_2[e] = 16384 + 0j for all e.
  - Each o_re = (i1*2+j1+1)*1024.
  - k=2 -> 2048, k=8 -> 3072, k=10 -> 4096.
  - Complex check: mat_1[0] = 0+16384j, mat_2[0] = 0+16384j -> k=0 gives o_re=-16384, o_im=0.
- Backpressure: random o_ready with about 50% duty -> the sequence of (o_idx, o_re, o_im) is identical to the o_ready=1 run. Outputs stay stable while o_valid && !o_ready.
- Saturation: mat_1[0] = mat_2[0] = 32767 + 32767j -> k=0 gives o_re=0 and o_im=32767 with o_ovr=1; ovr_flag=1 until the next accept clears it.
- Reset mid-job: deassert rst_n at k=5 -> all outputs return to their reset values immediately. A new start then produces k=0 first.
- Parametrisation: D1=2, D2=4 with random operands -> 64 elements matching the golden model bit-exactly, o_last at k=63, start_ready=0 throughout busy.

Source files
------------

// File: rtl/tensorproduct_stream.sv
// Sequential Kronecker product engine for complex fixed-point matrices.
// One complex multiplier is shared over all OUT_ELEMS result elements; the
// results stream out in row-major order with valid/ready backpressure.
//
// state | meaning
// IDLE  | waiting for a start handshake, operands may be captured
// RUN   | issuing one element per pipeline advance
// DRAIN | all elements issued, waiting for the last output handshake
module tensorproduct_stream #(
   parameter int N    = 16,
   parameter int FRAC = 14,
   parameter int D1   = 2,
   parameter int D2   = 2,
   localparam int DD        = D1 * D2,
   localparam int OUT_ELEMS = DD * DD,
   localparam int IDXW      = (OUT_ELEMS > 1) ? $clog2(OUT_ELEMS) : 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start_valid,
   output logic            start_ready,
   input  logic [N-1:0]    mat_1 [2*D1*D1],
   input  logic [N-1:0]    mat_2 [2*D2*D2],
   output logic            o_valid,
   input  logic            o_ready,
   output logic [N-1:0]    o_re,
   output logic [N-1:0]    o_im,
   output logic [IDXW-1:0] o_idx,
   output logic            o_last,
   output logic            o_ovr,
   output logic            ovr_flag,
   output logic            busy
);

   localparam int CW1 = (D1 > 1) ? $clog2(D1) : 1;
   localparam int CW2 = (D2 > 1) ? $clog2(D2) : 1;
   localparam int M1W = $clog2(2 * D1 * D1);
   localparam int M2W = $clog2(2 * D2 * D2);
   localparam logic signed [2*N:0] SMAX = (2*N+1)'((longint'(1) << (N - 1)) - 1);
   localparam logic signed [2*N:0] SMIN = -SMAX - 1;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t                r_state;
   logic [N-1:0]          r_m1 [2*D1*D1];
   logic [N-1:0]          r_m2 [2*D2*D2];
   logic [CW1-1:0]        r_i1, r_j1;
   logic [CW2-1:0]        r_i2, r_j2;
   logic [IDXW-1:0]       r_k;
   logic                  r_s1_valid, r_s1_last;
   logic [IDXW-1:0]       r_s1_idx;
   logic signed [2*N-1:0] r_ac, r_bd, r_ad, r_bc;

   logic                  w_adv, w_accept;
   logic [M1W-1:0]        w_e1_re, w_e1_im;
   logic [M2W-1:0]        w_e2_re, w_e2_im;
   logic signed [N-1:0]   w_a, w_b, w_c, w_d;
   logic signed [2*N:0]   w_re_full, w_im_full;
   logic [N:0]            w_re_sat, w_im_sat;

   // Arithmetic shift by FRAC (floor), then clamp; MSB of the result flags a clamp.
   function automatic logic [N:0] sat(input logic signed [2*N:0] v);
      logic signed [2*N:0] s;
      s = v >>> FRAC;
      if (s > SMAX)      sat = {1'b1, SMAX[N-1:0]};
      else if (s < SMIN) sat = {1'b1, SMIN[N-1:0]};
      else               sat = {1'b0, s[N-1:0]};
   endfunction

   assign w_adv       = !o_valid || o_ready;
   assign start_ready = (r_state == IDLE);
   assign busy        = (r_state != IDLE);
   assign w_accept    = start_valid && start_ready;

   assign w_e1_re = M1W'(2 * (int'(r_i1) * D1 + int'(r_j1)));
   assign w_e1_im = M1W'(2 * (int'(r_i1) * D1 + int'(r_j1)) + 1);
   assign w_e2_re = M2W'(2 * (int'(r_i2) * D2 + int'(r_j2)));
   assign w_e2_im = M2W'(2 * (int'(r_i2) * D2 + int'(r_j2)) + 1);
   assign w_a = r_m1[w_e1_re];
   assign w_b = r_m1[w_e1_im];
   assign w_c = r_m2[w_e2_re];
   assign w_d = r_m2[w_e2_im];

   assign w_re_full = (2*N+1)'(r_ac) - (2*N+1)'(r_bd);
   assign w_im_full = (2*N+1)'(r_ad) + (2*N+1)'(r_bc);
   assign w_re_sat  = sat(w_re_full);
   assign w_im_sat  = sat(w_im_full);

   // Control FSM, operand capture, issue counters and product stage S1.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         for (int e = 0; e < 2*D1*D1; e++) r_m1[e] <= '0;
         for (int e = 0; e < 2*D2*D2; e++) r_m2[e] <= '0;
         r_i1       <= '0;
         r_j1       <= '0;
         r_i2       <= '0;
         r_j2       <= '0;
         r_k        <= '0;
         r_s1_valid <= 1'b0;
         r_s1_last  <= 1'b0;
         r_s1_idx   <= '0;
         r_ac       <= '0;
         r_bd       <= '0;
         r_ad       <= '0;
         r_bc       <= '0;
      end else if (w_accept) begin
         r_m1    <= mat_1;
         r_m2    <= mat_2;
         r_i1    <= '0;
         r_j1    <= '0;
         r_i2    <= '0;
         r_j2    <= '0;
         r_k     <= '0;
         r_state <= RUN;
      end else begin
         case (r_state)
            RUN: begin
               if (w_adv) begin
                  r_s1_valid <= 1'b1;
                  r_s1_idx   <= r_k;
                  r_s1_last  <= (r_k == IDXW'(OUT_ELEMS - 1));
                  r_ac       <= w_a * w_c;
                  r_bd       <= w_b * w_d;
                  r_ad       <= w_a * w_d;
                  r_bc       <= w_b * w_c;
                  r_k        <= r_k + 1'b1;
                  if (r_j2 == CW2'(D2 - 1)) begin
                     r_j2 <= '0;
                     if (r_j1 == CW1'(D1 - 1)) begin
                        r_j1 <= '0;
                        if (r_i2 == CW2'(D2 - 1)) begin
                           r_i2 <= '0;
                           r_i1 <= (r_i1 == CW1'(D1 - 1)) ? '0 : r_i1 + 1'b1;
                        end else begin
                           r_i2 <= r_i2 + 1'b1;
                        end
                     end else begin
                        r_j1 <= r_j1 + 1'b1;
                     end
                  end else begin
                     r_j2 <= r_j2 + 1'b1;
                  end
                  if (r_k == IDXW'(OUT_ELEMS - 1)) r_state <= DRAIN;
               end
            end
            DRAIN: begin
               if (w_adv) r_s1_valid <= 1'b0;
               if (o_valid && o_ready && o_last) r_state <= IDLE;
            end
            default: begin
               if (w_adv) r_s1_valid <= 1'b0;
            end
         endcase
      end
   end

   // Output stage S2: complex combine, rescale, saturate, sticky overflow.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         o_valid  <= 1'b0;
         o_re     <= '0;
         o_im     <= '0;
         o_idx    <= '0;
         o_last   <= 1'b0;
         o_ovr    <= 1'b0;
         ovr_flag <= 1'b0;
      end else begin
         if (w_accept) ovr_flag <= 1'b0;
         if (w_adv) begin
            o_valid <= r_s1_valid;
            o_re    <= r_s1_valid ? w_re_sat[N-1:0] : '0;
            o_im    <= r_s1_valid ? w_im_sat[N-1:0] : '0;
            o_idx   <= r_s1_valid ? r_s1_idx : '0;
            o_last  <= r_s1_valid && r_s1_last;
            o_ovr   <= r_s1_valid && (w_re_sat[N] || w_im_sat[N]);
            if (r_s1_valid && (w_re_sat[N] || w_im_sat[N])) ovr_flag <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_tensorproduct_stream.sv
// Bench for tensorproduct_stream: a 2x2 (x) 2x2 instance and a 2x2 (x) 4x4 instance.
module tb_tensorproduct_stream;

   typedef struct {
      int idx;
      int re;
      int im;
      bit last;
      bit ovr;
   } elem_t;

   logic clk, rst_n;
   int   total = 0;
   int   bad   = 0;
   elem_t q_exp[$];
   elem_t q_obs[$];
   elem_t q_ref[$];

   // instance A: D1 = D2 = 2
   logic        sv_a, start_ready_a, o_valid_a, ready_a, o_last_a, o_ovr_a, ovr_flag_a, busy_a;
   logic [15:0] m1a [8];
   logic [15:0] m2a [8];
   logic [15:0] o_re_a, o_im_a;
   logic [3:0]  o_idx_a;

   // instance B: D1 = 2, D2 = 4
   logic        sv_b, start_ready_b, o_valid_b, ready_b, o_last_b, o_ovr_b, ovr_flag_b, busy_b;
   logic [15:0] m1b [8];
   logic [15:0] m2b [32];
   logic [15:0] o_re_b, o_im_b;
   logic [5:0]  o_idx_b;

   tensorproduct_stream #(.N(16), .FRAC(14), .D1(2), .D2(2)) dut_a (
      .clk(clk), .rst_n(rst_n), .start_valid(sv_a), .start_ready(start_ready_a),
      .mat_1(m1a), .mat_2(m2a), .o_valid(o_valid_a), .o_ready(ready_a),
      .o_re(o_re_a), .o_im(o_im_a), .o_idx(o_idx_a), .o_last(o_last_a),
      .o_ovr(o_ovr_a), .ovr_flag(ovr_flag_a), .busy(busy_a));

   tensorproduct_stream #(.N(16), .FRAC(14), .D1(2), .D2(4)) dut_b (
      .clk(clk), .rst_n(rst_n), .start_valid(sv_b), .start_ready(start_ready_b),
      .mat_1(m1b), .mat_2(m2b), .o_valid(o_valid_b), .o_ready(ready_b),
      .o_re(o_re_b), .o_im(o_im_b), .o_idx(o_idx_b), .o_last(o_last_b),
      .o_ovr(o_ovr_b), .ovr_flag(ovr_flag_b), .busy(busy_b));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // golden element: (a+jb)(c+jd), floor-shift by 14, clamp to 16-bit signed
   function automatic elem_t model(logic [15:0] a, logic [15:0] b, logic [15:0] c,
                                   logic [15:0] d, int k, int lastk);
      elem_t  e;
      longint re, im;
      bit     ov;
      ov = 1'b0;
      re = (longint'($signed(a)) * longint'($signed(c)) - longint'($signed(b)) * longint'($signed(d))) >>> 14;
      im = (longint'($signed(a)) * longint'($signed(d)) + longint'($signed(b)) * longint'($signed(c))) >>> 14;
      if (re > 32767)  begin re = 32767;  ov = 1'b1; end
      if (re < -32768) begin re = -32768; ov = 1'b1; end
      if (im > 32767)  begin im = 32767;  ov = 1'b1; end
      if (im < -32768) begin im = -32768; ov = 1'b1; end
      e.idx = k; e.re = int'(re); e.im = int'(im); e.last = (k == lastk); e.ovr = ov;
      return e;
   endfunction

   task automatic set_identity_a();
      for (int e = 0; e < 8; e++) begin m1a[e] = 16'd0; m2a[e] = 16'd0; end
      m1a[0] = 16'd16384; m1a[6] = 16'd16384;
      m2a[0] = 16'd16384; m2a[6] = 16'd16384;
   endtask

   task automatic set_order_a();
      for (int e = 0; e < 4; e++) begin
         m1a[2*e] = 16'((e + 1) * 1024); m1a[2*e+1] = 16'd0;
         m2a[2*e] = 16'd16384;           m2a[2*e+1] = 16'd0;
      end
   endtask

   // pushes the expected stream, then performs the start handshake
   task automatic start_a(input bit scramble_hold);
      for (int i1 = 0; i1 < 2; i1++)
         for (int i2 = 0; i2 < 2; i2++)
            for (int j1 = 0; j1 < 2; j1++)
               for (int j2 = 0; j2 < 2; j2++) begin
                  int e1, e2, k;
                  e1 = i1*2 + j1; e2 = i2*2 + j2; k = (i1*2 + i2)*4 + j1*2 + j2;
                  q_exp.push_back(model(m1a[2*e1], m1a[2*e1+1], m2a[2*e2], m2a[2*e2+1], k, 15));
               end
      @(negedge clk);
      total++;
      if (start_ready_a !== 1'b1) begin
         bad++; $display("FAIL start_ready_a idle: got %b want 1", start_ready_a);
      end
      sv_a = 1'b1;
      @(negedge clk);
      if (!scramble_hold) sv_a = 1'b0;
      total++;
      if (busy_a !== 1'b1 || start_ready_a !== 1'b0) begin
         bad++; $display("FAIL busy_after_accept: busy=%b start_ready=%b want 1/0", busy_a, start_ready_a);
      end
      if (scramble_hold)
         for (int e = 0; e < 8; e++) begin m1a[e] = 16'($urandom); m2a[e] = 16'($urandom); end
   endtask

   // collects handshaken elements of A until o_last, watching stall stability
   task automatic mon_a(input bit rnd, output int first_cyc, output int stall_bad, output bit tmo);
      logic [38:0] saved;
      bit          stalled;
      q_obs.delete();
      first_cyc = -1; stall_bad = 0; tmo = 1'b1; stalled = 1'b0; saved = '0;
      for (int cyc = 1; cyc <= 400; cyc++) begin
         @(negedge clk);
         if (stalled && {o_valid_a, o_idx_a, o_re_a, o_im_a, o_last_a, o_ovr_a} !== saved) stall_bad++;
         ready_a = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         if (o_valid_a && first_cyc < 0) first_cyc = cyc;
         stalled = o_valid_a && !ready_a;
         saved   = {o_valid_a, o_idx_a, o_re_a, o_im_a, o_last_a, o_ovr_a};
         if (o_valid_a && ready_a) begin
            elem_t ob;
            ob.idx = int'(o_idx_a); ob.re = int'($signed(o_re_a)); ob.im = int'($signed(o_im_a));
            ob.last = o_last_a; ob.ovr = o_ovr_a;
            q_obs.push_back(ob);
            if (o_last_a) begin tmo = 1'b0; break; end
         end
      end
   endtask

   task automatic test_reset();
      #3;
      total++;
      if (start_ready_a !== 1'b1 || o_valid_a !== 1'b0 || o_re_a !== 16'd0 || o_im_a !== 16'd0 ||
          o_idx_a !== 4'd0 || o_last_a !== 1'b0 || o_ovr_a !== 1'b0 || ovr_flag_a !== 1'b0 || busy_a !== 1'b0) begin
         bad++;
         $display("FAIL reset_state: sr=%b v=%b re=%h im=%h idx=%0d last=%b ovr=%b flag=%b busy=%b",
                  start_ready_a, o_valid_a, o_re_a, o_im_a, o_idx_a, o_last_a, o_ovr_a, ovr_flag_a, busy_a);
      end
      total++;
      if (start_ready_b !== 1'b1 || o_valid_b !== 1'b0 || busy_b !== 1'b0) begin
         bad++; $display("FAIL reset_state_b: sr=%b v=%b busy=%b", start_ready_b, o_valid_b, busy_b);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_identity();
      int fc, sb; bit tmo;
      set_identity_a();
      ready_a = 1'b1;
      start_a(1'b0);
      mon_a(1'b0, fc, sb, tmo);
      total++;
      if (tmo || q_obs.size() != 16) begin
         bad++; $display("FAIL identity_count: got %0d timeout=%b want 16", q_obs.size(), tmo);
      end
      total++;
      if (fc !== 2) begin bad++; $display("FAIL identity_latency: first valid at %0d want 2", fc); end
      while (q_obs.size() > 0 && q_exp.size() > 0) begin
         elem_t ob, ex;
         ob = q_obs.pop_front(); ex = q_exp.pop_front();
         total++;
         if (ob.idx !== ex.idx || ob.re !== ((ex.idx % 5 == 0) ? 16384 : 0) || ob.im !== 0 ||
             ob.last !== ex.last || ob.ovr !== 1'b0) begin
            bad++;
            $display("FAIL identity_elem: got idx=%0d re=%0d im=%0d last=%b ovr=%b want idx=%0d re=%0d im=0 last=%b",
                     ob.idx, ob.re, ob.im, ob.last, ob.ovr, ex.idx, (ex.idx % 5 == 0) ? 16384 : 0, ex.last);
         end
      end
      q_exp.delete();
      @(negedge clk);
      total++;
      if (ovr_flag_a !== 1'b0 || o_valid_a !== 1'b0 || start_ready_a !== 1'b1) begin
         bad++; $display("FAIL identity_done: flag=%b valid=%b sr=%b want 0/0/1", ovr_flag_a, o_valid_a, start_ready_a);
      end
   endtask

   task automatic test_ordering();
      int fc, sb; bit tmo;
      for (int pass = 0; pass < 2; pass++) begin
         set_order_a();
         if (pass == 1) begin m1a[0] = 16'd0; m1a[1] = 16'd16384; m2a[0] = 16'd0; m2a[1] = 16'd16384; end
         start_a(1'b0);
         mon_a(1'b0, fc, sb, tmo);
         total++;
         if (tmo || q_obs.size() != 16) begin
            bad++; $display("FAIL order_count: got %0d timeout=%b want 16", q_obs.size(), tmo);
         end
         while (q_obs.size() > 0 && q_exp.size() > 0) begin
            elem_t ob, ex;
            ob = q_obs.pop_front(); ex = q_exp.pop_front();
            total++;
            if (ob.idx !== ex.idx || ob.re !== ex.re || ob.im !== ex.im || ob.last !== ex.last || ob.ovr !== ex.ovr) begin
               bad++;
               $display("FAIL order_elem: got idx=%0d re=%0d im=%0d want idx=%0d re=%0d im=%0d",
                        ob.idx, ob.re, ob.im, ex.idx, ex.re, ex.im);
            end
            if (pass == 0 && (ob.idx == 2 || ob.idx == 8 || ob.idx == 10)) begin
               int want;
               want = (ob.idx == 2) ? 2048 : (ob.idx == 8) ? 3072 : 4096;
               total++;
               if (ob.re !== want) begin bad++; $display("FAIL order_k%0d: got %0d want %0d", ob.idx, ob.re, want); end
            end
            if (pass == 1 && ob.idx == 0) begin
               total++;
               if (ob.re !== -16384 || ob.im !== 0) begin
                  bad++; $display("FAIL complex_k0: got re=%0d im=%0d want -16384/0", ob.re, ob.im);
               end
            end
         end
         q_exp.delete();
      end
   endtask

   task automatic test_backpressure();
      int fc, sb; bit tmo;
      set_order_a();
      m1a[1] = 16'hF000; m1a[3] = 16'd3000; m2a[3] = 16'hE000; m2a[5] = 16'd7777;
      start_a(1'b0);
      mon_a(1'b0, fc, sb, tmo);
      q_ref = q_obs;
      start_a(1'b1);
      mon_a(1'b1, fc, sb, tmo);
      sv_a = 1'b0;
      total++;
      if (tmo || q_obs.size() != 16 || q_ref.size() != 16) begin
         bad++; $display("FAIL bp_count: got %0d ref %0d timeout=%b want 16", q_obs.size(), q_ref.size(), tmo);
      end
      total++;
      if (sb !== 0) begin bad++; $display("FAIL bp_stall_stable: got %0d changes want 0", sb); end
      void'(q_exp.pop_front());
      repeat (15) void'(q_exp.pop_front());
      while (q_obs.size() > 0 && q_exp.size() > 0 && q_ref.size() > 0) begin
         elem_t ob, ex, rf;
         ob = q_obs.pop_front(); ex = q_exp.pop_front(); rf = q_ref.pop_front();
         total++;
         if (ob.idx !== rf.idx || ob.re !== rf.re || ob.im !== rf.im || ob.idx !== ex.idx || ob.re !== ex.re || ob.im !== ex.im) begin
            bad++;
            $display("FAIL bp_elem: got idx=%0d re=%0d im=%0d want idx=%0d re=%0d im=%0d",
                     ob.idx, ob.re, ob.im, ex.idx, ex.re, ex.im);
         end
      end
      q_exp.delete(); q_ref.delete();
      ready_a = 1'b1;
   endtask

   task automatic test_saturation();
      int fc, sb; bit tmo;
      for (int e = 0; e < 8; e++) begin m1a[e] = 16'd0; m2a[e] = 16'd0; end
      m1a[0] = 16'd32767; m1a[1] = 16'd32767; m2a[0] = 16'd32767; m2a[1] = 16'd32767;
      start_a(1'b0);
      mon_a(1'b0, fc, sb, tmo);
      total++;
      if (tmo || q_obs.size() != 16) begin bad++; $display("FAIL sat_count: got %0d want 16", q_obs.size()); end
      while (q_obs.size() > 0 && q_exp.size() > 0) begin
         elem_t ob, ex;
         ob = q_obs.pop_front(); ex = q_exp.pop_front();
         total++;
         if (ob.idx !== ex.idx || ob.re !== ex.re || ob.im !== ex.im || ob.ovr !== ex.ovr) begin
            bad++; $display("FAIL sat_elem: got idx=%0d re=%0d im=%0d ovr=%b want idx=%0d re=%0d im=%0d ovr=%b",
                            ob.idx, ob.re, ob.im, ob.ovr, ex.idx, ex.re, ex.im, ex.ovr);
         end
         if (ob.idx == 0) begin
            total++;
            if (ob.re !== 0 || ob.im !== 32767 || ob.ovr !== 1'b1) begin
               bad++; $display("FAIL sat_k0: got re=%0d im=%0d ovr=%b want 0/32767/1", ob.re, ob.im, ob.ovr);
            end
         end
      end
      q_exp.delete();
      repeat (4) @(negedge clk);
      total++;
      if (ovr_flag_a !== 1'b1) begin bad++; $display("FAIL sat_flag_hold: got %b want 1", ovr_flag_a); end
      set_identity_a();
      start_a(1'b0);
      total++;
      if (ovr_flag_a !== 1'b0) begin bad++; $display("FAIL sat_flag_clear: got %b want 0", ovr_flag_a); end
      mon_a(1'b0, fc, sb, tmo);
      q_exp.delete(); q_obs.delete();
   endtask

   task automatic test_reset_midjob();
      int fc, sb; bit tmo, seen;
      set_order_a();
      start_a(1'b0);
      q_exp.delete();
      seen = 1'b0;
      for (int cyc = 0; cyc < 100 && !seen; cyc++) begin
         @(negedge clk);
         if (o_valid_a && o_idx_a == 4'd5) seen = 1'b1;
      end
      total++;
      if (!seen) begin bad++; $display("FAIL midjob_reach_k5: got timeout want k=5"); end
      rst_n = 1'b0;
      #1;
      total++;
      if (start_ready_a !== 1'b1 || o_valid_a !== 1'b0 || o_re_a !== 16'd0 || o_im_a !== 16'd0 ||
          o_idx_a !== 4'd0 || o_last_a !== 1'b0 || o_ovr_a !== 1'b0 || ovr_flag_a !== 1'b0 || busy_a !== 1'b0) begin
         bad++; $display("FAIL midjob_reset: sr=%b v=%b re=%h im=%h idx=%0d busy=%b want reset values",
                         start_ready_a, o_valid_a, o_re_a, o_im_a, o_idx_a, busy_a);
      end
      @(negedge clk);
      rst_n = 1'b1;
      start_a(1'b0);
      mon_a(1'b0, fc, sb, tmo);
      total++;
      if (tmo || q_obs.size() != 16 || q_obs[0].idx !== 0) begin
         bad++; $display("FAIL midjob_restart: got count=%0d first_idx=%0d want 16/0",
                         q_obs.size(), (q_obs.size() > 0) ? q_obs[0].idx : -1);
      end
      while (q_obs.size() > 0 && q_exp.size() > 0) begin
         elem_t ob, ex;
         ob = q_obs.pop_front(); ex = q_exp.pop_front();
         total++;
         if (ob.idx !== ex.idx || ob.re !== ex.re || ob.im !== ex.im) begin
            bad++; $display("FAIL midjob_elem: got idx=%0d re=%0d want idx=%0d re=%0d", ob.idx, ob.re, ex.idx, ex.re);
         end
      end
      q_exp.delete();
   endtask

   task automatic test_param();
      bit          tmo;
      int          sr_bad, cnt;
      for (int e = 0; e < 8; e++)  m1b[e] = 16'($urandom);
      for (int e = 0; e < 32; e++) m2b[e] = 16'($urandom);
      for (int i1 = 0; i1 < 2; i1++)
         for (int i2 = 0; i2 < 4; i2++)
            for (int j1 = 0; j1 < 2; j1++)
               for (int j2 = 0; j2 < 4; j2++) begin
                  int e1, e2, k;
                  e1 = i1*2 + j1; e2 = i2*4 + j2; k = (i1*4 + i2)*8 + j1*4 + j2;
                  q_exp.push_back(model(m1b[2*e1], m1b[2*e1+1], m2b[2*e2], m2b[2*e2+1], k, 63));
               end
      @(negedge clk);
      sv_b = 1'b1;
      @(negedge clk);
      sv_b = 1'b0;
      q_obs.delete(); tmo = 1'b1; sr_bad = 0;
      for (int cyc = 0; cyc < 600; cyc++) begin
         @(negedge clk);
         if (busy_b && start_ready_b) sr_bad++;
         ready_b = 1'($urandom_range(0, 1));
         if (o_valid_b && ready_b) begin
            elem_t ob;
            ob.idx = int'(o_idx_b); ob.re = int'($signed(o_re_b)); ob.im = int'($signed(o_im_b));
            ob.last = o_last_b; ob.ovr = o_ovr_b;
            q_obs.push_back(ob);
            if (o_last_b) begin tmo = 1'b0; break; end
         end
      end
      total++;
      if (tmo || q_obs.size() != 64) begin bad++; $display("FAIL param_count: got %0d timeout=%b want 64", q_obs.size(), tmo); end
      total++;
      if (sr_bad !== 0) begin bad++; $display("FAIL param_start_ready_busy: got %0d cycles want 0", sr_bad); end
      cnt = 0;
      while (q_obs.size() > 0 && q_exp.size() > 0) begin
         elem_t ob, ex;
         ob = q_obs.pop_front(); ex = q_exp.pop_front();
         total++;
         if (ob.idx !== ex.idx || ob.re !== ex.re || ob.im !== ex.im || ob.last !== ex.last || ob.ovr !== ex.ovr) begin
            bad++;
            $display("FAIL param_elem: got idx=%0d re=%0d im=%0d last=%b ovr=%b want idx=%0d re=%0d im=%0d last=%b ovr=%b",
                     ob.idx, ob.re, ob.im, ob.last, ob.ovr, ex.idx, ex.re, ex.im, ex.last, ex.ovr);
         end
         cnt++;
      end
      q_exp.delete();
      @(negedge clk);
      total++;
      if (busy_b !== 1'b0 || start_ready_b !== 1'b1) begin
         bad++; $display("FAIL param_done: busy=%b sr=%b want 0/1", busy_b, start_ready_b);
      end
   endtask

   initial begin
      rst_n = 1'b0; sv_a = 1'b0; sv_b = 1'b0; ready_a = 1'b1; ready_b = 1'b1;
      for (int e = 0; e < 8; e++)  begin m1a[e] = 16'd0; m2a[e] = 16'd0; m1b[e] = 16'd0; end
      for (int e = 0; e < 32; e++) m2b[e] = 16'd0;
      test_reset();
      test_identity();
      test_ordering();
      test_backpressure();
      test_saturation();
      test_reset_midjob();
      test_param();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got no completion want finish");
      $fatal(1, "watchdog");
   end

endmodule
